control_unit_gen: RTL
=====================

Name: control_unit_gen

Overview:
- Parametrised multi-cycle control unit: program counter, instruction register and a Moore FSM that decodes each instruction into datapath control strobes.
- Successor to the fixed 16-bit, six-opcode controller. Adds configurable field widths, absolute jump, branch-if-zero, a sticky illegal-opcode trap and status outputs.
- The instruction ROM is external, synchronous, with 1-cycle read latency.
- Sits between the instruction memory and the register-file/ALU/data-memory datapath.

Parameters:
- IW, 16, instruction width; must equal OPW + 3*RAW.
- OPW, 4, opcode width (opcode = IR[IW-1:IW-OPW]).
- RAW, 4, register-file address width.
- PCW, 7, PC width; must be <= DAW (localparam DAW = IW-OPW-RAW, data-address width, default 8).
- ALUW, 3, ALU select width.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Instr_Addr  output  PCW  ROM address, always equal to the PC register.
- Instr_Data  input  IW  ROM read data, valid 1 cycle after Instr_Addr changes.
- RF_Ra_Zero  input  1  high when register-file port A reads zero; used by BRZ.
- IR_Out  output  IW  instruction register.
- D_Addr  output  DAW  data-memory address.
- D_Wr  output  1  data-memory write strobe.
- RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr  output  RAW each  register-file addresses.
- RF_W_en  output  1  register-file write enable.
- RF_s  output  1  write-data select: 1 = memory, 0 = ALU.
- ALU_s0  output  ALUW  ALU function select.
- outState, nextState  output  4  current and next FSM state.
- Halted  output  1  high in HALT.
- Illegal  output  1  high in ERR.

Behaviour:
- Reset low, asynchronous: state=INIT, PC=0, IR=0. All strobes and addresses go to 0; Halted=0, Illegal=0. Reset asserted mid-instruction aborts it with no further writes.
- State encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, HALT=8, SUB=9, JUMP=A, BRZ=B, ERR=C, PAUSE=D, JWAIT=E.
- Outputs are Moore: combinational from state and IR. Every output not listed for a state is 0, including the address outputs.
- INIT -> FETCH (1 cycle).
- FETCH: IR <= Instr_Data, PC <= PC+1 (wraps modulo 2^PCW). Next state DECODE.
- DECODE: branch on opcode. 0 NOOP, 1 STORE, 2 LOAD_A, 3 ADD, 4 SUB, 5 HALT, 6 JUMP, 7 BRZ, any other value ERR.
- Instruction field map (default widths):
  - ADD/SUB: Ra=IR[11:8], Rb=IR[7:4], W=IR[3:0].
  - LOAD: D_Addr=IR[11:4], W=IR[3:0].
  - STORE: Ra=IR[11:8], D_Addr=IR[7:0].
  - JUMP/BRZ: target=IR[PCW-1:0]; BRZ test register Ra=IR[11:8].
  - Wider configurations use the same field order, scaled by RAW.
- LOAD_A: D_Addr, RF_W_Addr, RF_s=1 -> LOAD_B.
- LOAD_B: same as LOAD_A plus RF_W_en=1 -> FETCH.
- STORE: D_Addr, RF_Ra_Addr, D_Wr=1 -> FETCH.
- ADD: Ra, Rb, W, RF_W_en=1, ALU_s0=1 -> FETCH. SUB is identical with ALU_s0=2.
- NOOP -> FETCH.
- JUMP: PC <= target -> JWAIT.
- BRZ: drives RF_Ra_Addr; RF_Ra_Zero is sampled in this cycle. If 1: PC <= target -> JWAIT; otherwise -> FETCH with PC unchanged.
- JWAIT: one idle cycle so the ROM output reflects the new PC -> FETCH.
- HALT and ERR are terminal: they self-loop until Reset and the PC is frozen.
- Latency: 3 cycles per ALU, STORE or NOOP instruction; 4 for LOAD, JUMP and taken BRZ. The first FETCH occurs 1 cycle after Reset deasserts.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- Defined: adds input Step (1 bit). Every state that would go to FETCH (except INIT and JWAIT) goes to PAUSE instead. PAUSE holds all outputs at 0 and goes to FETCH in the cycle Step=1.
- Undefined: no Step port, PAUSE is unreachable, and timing is exactly as in Behaviour.

Test Plan:
- ROM[0]=16'h3ABC, release Reset at cycle 0 -> cycle 3: outState=7, ALU_s0=1, Ra=A, Rb=B, W=C, RF_W_en=1, nextState=1.
- ROM[1]=16'h2AB3 -> LOAD_A: D_Addr=AB, RF_s=1, RF_W_en=0. Next cycle LOAD_B: RF_W_en=1, W=3.
- ROM[2]=16'h6005 -> JUMP then JWAIT; PC=5; the next FETCH loads ROM[5].
- ROM[5]=16'h7410 with RF_Ra_Zero=1 -> PC=0x10, via JWAIT. Repeat with RF_Ra_Zero=0 -> FETCH with PC=6.
- Opcode 4'hF -> outState=C, Illegal=1, PC frozen. Opcode 5 -> outState=8, Halted=1. Drop Reset mid-LOAD_A -> outState=0, all outputs 0 immediately, without waiting for a clock edge.
- CU_SINGLE_STEP_EN: after ADD, state=D and stays there 5 cycles with Step=0; Step=1 -> FETCH on the next edge.

Source files
------------

// File: rtl/control_unit_gen.sv
// control_unit_gen: multi-cycle control unit with program counter, instruction
// register and a Moore FSM that turns each instruction into datapath strobes.
// The instruction ROM is external and synchronous (1-cycle read latency).
// Optional feature: define CU_SINGLE_STEP_EN to add the Step input and the
// PAUSE state that holds the machine after every completed instruction.
module control_unit_gen #(
    parameter int IW   = 16,
    parameter int OPW  = 4,
    parameter int RAW  = 4,
    parameter int PCW  = 7,
    parameter int ALUW = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic                  Step,
`endif
    output logic [PCW-1:0]        Instr_Addr,
    input  logic [IW-1:0]         Instr_Data,
    input  logic                  RF_Ra_Zero,
    output logic [IW-1:0]         IR_Out,
    output logic [IW-OPW-RAW-1:0] D_Addr,
    output logic                  D_Wr,
    output logic [RAW-1:0]        RF_Ra_Addr,
    output logic [RAW-1:0]        RF_Rb_Addr,
    output logic [RAW-1:0]        RF_W_Addr,
    output logic                  RF_W_en,
    output logic                  RF_s,
    output logic [ALUW-1:0]       ALU_s0,
    output logic [3:0]            outState,
    output logic [3:0]            nextState,
    output logic                  Halted,
    output logic                  Illegal
);

    // Data-address width: what is left of the word after opcode and one register field.
    localparam int DAW = IW - OPW - RAW;

    typedef enum logic [3:0] {
        S_INIT   = 4'h0,
        S_FETCH  = 4'h1,
        S_DECODE = 4'h2,
        S_NOOP   = 4'h3,
        S_LOAD_A = 4'h4,
        S_LOAD_B = 4'h5,
        S_STORE  = 4'h6,
        S_ADD    = 4'h7,
        S_HALT   = 4'h8,
        S_SUB    = 4'h9,
        S_JUMP   = 4'hA,
        S_BRZ    = 4'hB,
        S_ERR    = 4'hC,
        S_PAUSE  = 4'hD,
        S_JWAIT  = 4'hE
    } state_t;

    // Where an instruction goes once it has finished its work.
`ifdef CU_SINGLE_STEP_EN
    localparam state_t S_DONE = S_PAUSE;
`else
    localparam state_t S_DONE = S_FETCH;
`endif

    state_t         state_q;
    state_t         state_n;
    logic [PCW-1:0] pc_q;
    logic [IW-1:0]  ir_q;

    // Instruction fields; wider configurations keep the same order scaled by RAW.
    logic [OPW-1:0] opcode;
    logic [RAW-1:0] ra_fld;
    logic [RAW-1:0] rb_fld;
    logic [RAW-1:0] w_fld;
    logic [DAW-1:0] ld_addr;
    logic [DAW-1:0] st_addr;
    logic [PCW-1:0] target;

    assign opcode  = ir_q[IW-1 -: OPW];
    assign ra_fld  = ir_q[IW-OPW-1 -: RAW];
    assign rb_fld  = ir_q[IW-OPW-RAW-1 -: RAW];
    assign w_fld   = ir_q[RAW-1:0];
    assign ld_addr = ir_q[IW-OPW-1 -: DAW];
    assign st_addr = ir_q[DAW-1:0];
    assign target  = ir_q[PCW-1:0];

    assign Instr_Addr = pc_q;
    assign IR_Out     = ir_q;
    assign outState   = state_q;
    // While reset is held the register cannot leave INIT, so report that.
    assign nextState  = Reset ? state_n : S_INIT;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_n;
        end
    end

    // PC and IR: load on FETCH, redirect on JUMP and on a taken BRZ.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q <= Instr_Data;
                    pc_q <= pc_q + PCW'(1);
                end
                S_JUMP: pc_q <= target;
                S_BRZ: begin
                    if (RF_Ra_Zero) begin
                        pc_q <= target;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic, including opcode decode.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_INIT:   state_n = S_FETCH;
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPW'(0): state_n = S_NOOP;
                    OPW'(1): state_n = S_STORE;
                    OPW'(2): state_n = S_LOAD_A;
                    OPW'(3): state_n = S_ADD;
                    OPW'(4): state_n = S_SUB;
                    OPW'(5): state_n = S_HALT;
                    OPW'(6): state_n = S_JUMP;
                    OPW'(7): state_n = S_BRZ;
                    default: state_n = S_ERR;
                endcase
            end
            S_NOOP:   state_n = S_DONE;
            S_LOAD_A: state_n = S_LOAD_B;
            S_LOAD_B: state_n = S_DONE;
            S_STORE:  state_n = S_DONE;
            S_ADD:    state_n = S_DONE;
            S_SUB:    state_n = S_DONE;
            S_JUMP:   state_n = S_JWAIT;
            S_BRZ:    state_n = RF_Ra_Zero ? S_JWAIT : S_DONE;
            S_JWAIT:  state_n = S_FETCH;
            S_HALT:   state_n = S_HALT;
            S_ERR:    state_n = S_ERR;
`ifdef CU_SINGLE_STEP_EN
            S_PAUSE:  state_n = Step ? S_FETCH : S_PAUSE;
`else
            S_PAUSE:  state_n = S_FETCH;
`endif
            default:  state_n = S_ERR;
        endcase
    end

    // Moore outputs: every strobe and address is zero unless the state drives it.
    always_comb begin
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        RF_W_Addr  = '0;
        RF_W_en    = 1'b0;
        RF_s       = 1'b0;
        ALU_s0     = '0;
        Halted     = 1'b0;
        Illegal    = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                D_Addr    = ld_addr;
                RF_W_Addr = w_fld;
                RF_s      = 1'b1;
            end
            S_LOAD_B: begin
                D_Addr    = ld_addr;
                RF_W_Addr = w_fld;
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_Addr     = st_addr;
                RF_Ra_Addr = ra_fld;
                D_Wr       = 1'b1;
            end
            S_ADD: begin
                RF_Ra_Addr = ra_fld;
                RF_Rb_Addr = rb_fld;
                RF_W_Addr  = w_fld;
                RF_W_en    = 1'b1;
                ALU_s0     = ALUW'(1);
            end
            S_SUB: begin
                RF_Ra_Addr = ra_fld;
                RF_Rb_Addr = rb_fld;
                RF_W_Addr  = w_fld;
                RF_W_en    = 1'b1;
                ALU_s0     = ALUW'(2);
            end
            S_BRZ:  RF_Ra_Addr = ra_fld;
            S_HALT: Halted     = 1'b1;
            S_ERR:  Illegal    = 1'b1;
            default: ;
        endcase
    end

endmodule
